// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch/decode/execute/write-back control FSM.
// Owns the PC, the retired count and the data-memory write strobe.
module exec_sequencer #(
  parameter int INSTR_BIT = 8,
  parameter int TIMEOUT   = 255,
  parameter int CNT_BIT   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 St,
  input  logic                 halt,
  input  logic                 pc_src,
  input  logic                 jump,
  input  logic [INSTR_BIT-1:0] jump_addr,
  input  logic                 dec_write_enable,
  input  logic                 alu_done,
  output logic [INSTR_BIT-1:0] pc,
  output logic                 ir_load,
  output logic                 mem_write_enable,
  output logic                 alu_start,
  output logic                 running,
  output logic                 error,
  output logic [CNT_BIT-1:0]   instr_count
);

  localparam int WD_BIT = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_BIT-1:0] WD_LAST = WD_BIT'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_BIT-1:0] pc_q, pc_d;
  logic [CNT_BIT-1:0]   cnt_q, cnt_d;
  logic [WD_BIT-1:0]    wd_q, wd_d;
  logic                 ir_load_q, ir_load_d;
  logic                 mwe_q, mwe_d;
  logic                 alu_start_q, alu_start_d;
  logic                 running_q, running_d;
  logic                 error_q, error_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (St) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        wd_d    = '0;
        state_d = halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        // wd_q counts EXEC cycles already spent without alu_done
        if (alu_done) begin
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        pc_d    = (pc_src & jump) ? jump_addr : pc_q + 1'b1;
        if (~&cnt_q) cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ir_load_d   = (state_d == S_FETCH);
    alu_start_d = (state_q == S_DECODE) && (state_d == S_EXEC);
    mwe_d       = (state_d == S_WB) && dec_write_enable;
    running_d   = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                  (state_d == S_EXEC) || (state_d == S_WB);
    error_d     = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      ir_load_q   <= 1'b0;
      mwe_q       <= 1'b0;
      alu_start_q <= 1'b0;
      running_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      ir_load_q   <= ir_load_d;
      mwe_q       <= mwe_d;
      alu_start_q <= alu_start_d;
      running_q   <= running_d;
      error_q     <= error_d;
    end
  end

  assign pc               = pc_q;
  assign instr_count      = cnt_q;
  assign ir_load          = ir_load_q;
  assign mem_write_enable = mwe_q;
  assign alu_start        = alu_start_q;
  assign running          = running_q;
  assign error            = error_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer (TIMEOUT=4).
// Checks are taken 1 time unit after each rising edge.
module tb_exec_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        St = 1'b0;
  logic        halt = 1'b0;
  logic        pc_src = 1'b0;
  logic        jump = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        dec_write_enable = 1'b0;
  logic        alu_done = 1'b0;
  logic [7:0]  pc;
  logic        ir_load;
  logic        mem_write_enable;
  logic        alu_start;
  logic        running;
  logic        error;
  logic [15:0] instr_count;

  int n_tot = 0;
  int n_bad = 0;

  exec_sequencer #(
    .INSTR_BIT(8),
    .TIMEOUT(4),
    .CNT_BIT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .St(St),
    .halt(halt),
    .pc_src(pc_src),
    .jump(jump),
    .jump_addr(jump_addr),
    .dec_write_enable(dec_write_enable),
    .alu_done(alu_done),
    .pc(pc),
    .ir_load(ir_load),
    .mem_write_enable(mem_write_enable),
    .alu_start(alu_start),
    .running(running),
    .error(error),
    .instr_count(instr_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Entered in FETCH; returns in the following FETCH.
  task automatic do_instr(input int n, input logic we,
                          input logic src, input logic jmp,
                          input logic [7:0] tgt, input logic [7:0] cur,
                          input logic [7:0] nxt, input logic [15:0] cnt);
    chk("f_irld", ir_load, 1);
    chk("f_pc", pc, cur);
    chk("f_run", running, 1);
    chk("f_cnt", instr_count, cnt);
    chk("f_start", alu_start, 0);
    halt = 0;
    pc_src = src;
    jump = jmp;
    jump_addr = tgt;
    dec_write_enable = we;
    alu_done = 0;
    step();
    chk("d_irld", ir_load, 0);
    chk("d_start", alu_start, 0);
    step();
    chk("e1_start", alu_start, 1);
    chk("e1_mwe", mem_write_enable, 0);
    alu_done = (n == 1);
    for (int c = 2; c <= n; c++) begin
      step();
      chk("ex_start", alu_start, 0);
      chk("ex_mwe", mem_write_enable, 0);
      alu_done = (c == n);
    end
    step();
    alu_done = 0;
    chk("wb_mwe", mem_write_enable, we);
    chk("wb_pc", pc, cur);
    chk("wb_run", running, 1);
    chk("wb_err", error, 0);
    step();
    chk("n_pc", pc, nxt);
    chk("n_cnt", instr_count, cnt + 16'd1);
    chk("n_mwe", mem_write_enable, 0);
    pc_src = 0;
    jump = 0;
    dec_write_enable = 0;
  endtask

  task automatic start();
    St = 1;
    step();
    St = 0;
  endtask

  initial begin
    step();
    step();
    chk("rst_pc", pc, 0);
    chk("rst_irld", ir_load, 0);
    chk("rst_mwe", mem_write_enable, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_run", running, 0);
    chk("rst_err", error, 0);
    chk("rst_cnt", instr_count, 0);
    RST = 1;
    step();
    chk("idle_run", running, 0);
    start();

    // sequential run, 5 cycles each; St held high during one
    do_instr(2, 1, 0, 0, 8'h00, 8'h00, 8'h01, 16'd0);
    St = 1;
    do_instr(2, 1, 0, 0, 8'h00, 8'h01, 8'h02, 16'd1);
    St = 0;
    do_instr(2, 1, 0, 0, 8'h00, 8'h02, 8'h03, 16'd2);
    chk("seq_cnt", instr_count, 3);
    do_instr(1, 0, 0, 0, 8'h00, 8'h03, 8'h04, 16'd3);
    do_instr(3, 0, 0, 1, 8'h20, 8'h04, 8'h05, 16'd4);
    do_instr(2, 1, 1, 0, 8'h40, 8'h05, 8'h06, 16'd5);
    do_instr(2, 0, 0, 0, 8'h00, 8'h06, 8'h07, 16'd6);

    // halt at pc 7
    chk("h_pc", pc, 7);
    halt = 1;
    alu_done = 1;
    step();
    chk("h_d_start", alu_start, 0);
    step();
    halt = 0;
    alu_done = 0;
    chk("h_run", running, 0);
    chk("h_start", alu_start, 0);
    chk("h_irld", ir_load, 0);
    chk("h_pc", pc, 7);
    chk("h_cnt", instr_count, 7);
    step();
    step();
    chk("h_hold_pc", pc, 7);
    chk("h_hold_run", running, 0);
    start();

    // branch chain and wrap
    do_instr(2, 0, 1, 1, 8'h05, 8'h00, 8'h05, 16'd0);
    do_instr(2, 1, 1, 1, 8'h40, 8'h05, 8'h40, 16'd1);
    do_instr(1, 0, 1, 1, 8'hFF, 8'h40, 8'hFF, 16'd2);
    do_instr(2, 0, 0, 1, 8'h33, 8'hFF, 8'h00, 16'd3);

    // watchdog expiry
    dec_write_enable = 1;
    alu_done = 0;
    step();
    step();
    chk("wd_start", alu_start, 1);
    for (int c = 2; c <= 4; c++) begin
      step();
      chk("wd_err_early", error, 0);
      chk("wd_mwe", mem_write_enable, 0);
    end
    step();
    chk("wd_err", error, 1);
    chk("wd_run", running, 0);
    chk("wd_mwe_err", mem_write_enable, 0);
    chk("wd_pc", pc, 0);
    chk("wd_cnt", instr_count, 4);
    dec_write_enable = 0;
    step();
    chk("wd_err_hold", error, 1);
    start();
    chk("wd_err_clr", error, 0);
    do_instr(4, 1, 0, 0, 8'h00, 8'h00, 8'h01, 16'd0);

    // reset during EXEC
    dec_write_enable = 1;
    step();
    step();
    chk("mr_start", alu_start, 1);
    #2;
    RST = 0;
    #1;
    chk("mr_pc", pc, 0);
    chk("mr_start0", alu_start, 0);
    chk("mr_run", running, 0);
    chk("mr_cnt", instr_count, 0);
    chk("mr_mwe", mem_write_enable, 0);
    alu_done = 1;
    step();
    chk("mr_mwe_edge", mem_write_enable, 0);
    chk("mr_run_edge", running, 0);
    RST = 1;
    alu_done = 0;
    dec_write_enable = 0;
    step();
    chk("mr_idle_run", running, 0);
    chk("mr_idle_irld", ir_load, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle control FSM for the matrix processor. Sequences fetch, decode, ALU execute and write-back for each instruction. Owns the program counter and gates the data-memory write enable. Sits between the start input, the instruction memory and decoder, and the matrix ALU, and replaces the free-running per-clock PC update with a handshaked, instruction-at-a-time schedule.

## Interface

Parameters:
- INSTR_BIT, 8: program counter width; instruction memory holds 2^INSTR_BIT words.
- TIMEOUT, 255: maximum EXEC cycles to wait for alu_done before entering ERR (≥1).
- CNT_BIT, 16: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- St  in  1  start request, level sampled per cycle.
- halt  in  1  decoder: current instruction is the terminating instruction.
- pc_src  in  1  decoder: current instruction is a branch.
- jump  in  1  external branch enable.
- jump_addr  in  INSTR_BIT  decoder branch target.
- dec_write_enable  in  1  decoder: instruction writes data memory.
- alu_done  in  1  ALU result valid.
- pc  out  INSTR_BIT  instruction memory address.
- ir_load  out  1  latch instruction memory output into decoder.
- mem_write_enable  out  1  data memory write strobe.
- alu_start  out  1  single-cycle ALU launch pulse.
- running  out  1  high in FETCH/DECODE/EXEC/WB.
- error  out  1  high in ERR.
- instr_count  out  CNT_BIT  instructions retired since last start.

## Operation

- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR. Reset state is IDLE.
- IDLE: St=1 moves to FETCH with pc=0 and instr_count=0.
- FETCH: ir_load=1 for exactly one cycle, then DECODE.
- DECODE: if halt=1, go to HALT. pc is not advanced and instr_count is not incremented. Otherwise go to EXEC.
- EXEC:
  - alu_start=1 on the first EXEC cycle only.
  - alu_done is sampled every EXEC cycle, including the first. alu_done=1 moves to WB.
  - A watchdog counts EXEC cycles. If it reaches TIMEOUT cycles without alu_done, go to ERR.
- WB:
  - mem_write_enable = dec_write_enable for one cycle.
  - pc ← jump_addr if (pc_src & jump), else pc+1, modulo 2^INSTR_BIT (wrap 2^INSTR_BIT−1 → 0, no flag).
  - instr_count increments, saturating at all-ones.
  - Next state is FETCH.
- HALT and ERR:
  - running=0. pc and instr_count hold.
  - St=1 restarts: pc=0, instr_count=0, error cleared, next state FETCH.
- St is ignored while running.
- alu_done outside EXEC is ignored.
- mem_write_enable is never asserted outside WB.

## Timing

- Reset: at RST=0, asynchronously force state=IDLE and pc=0. All outputs are 0: ir_load, mem_write_enable, alu_start, running, error, instr_count. Watchdog is cleared. Reset mid-instruction aborts with no write strobe.
- St in IDLE/HALT/ERR at edge k: FETCH in cycle k+1.
- Non-halt instruction with alu_done first seen n cycles after alu_start (n≥1, alu_done in the alu_start cycle counts as n=1) occupies FETCH + DECODE + n EXEC + WB = n+3 cycles.
- The new pc is visible the cycle after WB, in the next FETCH.
- Watchdog: alu_done arriving on EXEC cycle TIMEOUT is accepted. Absence through cycle TIMEOUT means error=1 from the following cycle.
- All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.

## Test plan

- Reset and start: hold RST=0, check all outputs 0. Release RST and pulse St. Check FETCH→DECODE→EXEC, with alu_start high exactly one cycle and pc=0.
- Sequential run: 3 non-branch instructions, alu_done after 2 cycles each, dec_write_enable=1. Expect pc 0→1→2→3, three one-cycle mem_write_enable pulses, 5 cycles per instruction, instr_count=3.
- Branch: pc_src=1, jump=1, jump_addr=8'h40 at pc=5. Expect next FETCH at pc=0x40. With jump=0, expect pc=6.
- Halt and restart: halt=1 at pc=7. Expect HALT, running=0, pc=7 held, no ALU launch. St=1 restarts at pc=0 with instr_count=0.
- Watchdog: TIMEOUT=4, alu_done never asserted. Expect error=1 after 4 EXEC cycles with no mem_write_enable. Repeat with alu_done on cycle 4: WB is entered and no error.
- Wrap and reset mid-op: pc=255, no branch, expect pc=0 after WB. Assert RST=0 during EXEC: immediate IDLE, outputs 0, no write strobe.
